uart_receiver: RTL and testbench

Parameterized UART receiver, the receive-side counterpart of the team's UART transmitter.
- Oversamples the asynchronous serial line rx_din on rx_clk, runs at OVERSAMPLE x baud.
- Validates the start bit at mid-bit, then samples DATA_WIDTH_NUMBER data bits LSB-first and STOP_BITS_NUMBER stop bits at mid-bit.
- Presents the parallel word with a one-cycle rx_done strobe and a frame_err flag.

---
 rtl/uart_receiver.sv | 118 +++++++++++
 tb/tb_uart_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: mid-bit sampling of start, LSB-first data and stop bits,
// with a one-cycle rx_done strobe and a sticky-per-frame framing error flag.
module uart_receiver #(
   parameter int DATA_WIDTH_NUMBER = 8,
   parameter int STOP_BITS_NUMBER  = 2,
   parameter int OVERSAMPLE        = 16
) (
   input  logic                         rx_clk,
   input  logic                         rst_n,
   input  logic                         rx_din,
   output logic [DATA_WIDTH_NUMBER-1:0] data_out,
   output logic                         rx_done,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_WIDTH_NUMBER);
   localparam int STOP_W = (STOP_BITS_NUMBER > 1) ? $clog2(STOP_BITS_NUMBER) : 1;

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH_NUMBER - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS_NUMBER - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                       state_reg;
   logic                         rx_meta_reg;
   logic                         rx_s_reg;
   logic                         rx_s_d_reg;
   logic [TICK_W-1:0]            tick_cnt_reg;
   logic [BIT_W-1:0]             bit_cnt_reg;
   logic [STOP_W-1:0]            stop_cnt_reg;
   logic [DATA_WIDTH_NUMBER-1:0] shift_reg;
   logic                         err_acc_reg;

   always_ff @(posedge rx_clk) begin
      if (!rst_n) begin
         rx_meta_reg  <= 1'b1;
         rx_s_reg     <= 1'b1;
         rx_s_d_reg   <= 1'b1;
         state_reg    <= IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= '0;
         shift_reg    <= '0;
         err_acc_reg  <= 1'b0;
         data_out     <= '0;
         rx_done      <= 1'b0;
         frame_err    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         rx_meta_reg <= rx_din;
         rx_s_reg    <= rx_meta_reg;
         rx_s_d_reg  <= rx_s_reg;
         rx_done     <= 1'b0;
         // busy trails the state by one cycle so it also covers the rx_done cycle
         busy        <= (state_reg != IDLE);

         case (state_reg)
            IDLE: begin
               if (!rx_s_reg && rx_s_d_reg) begin
                  state_reg    <= START;
                  tick_cnt_reg <= '0;
               end
            end
            START: begin
               if (tick_cnt_reg == TICK_HALF) begin
                  if (!rx_s_reg) begin
                     state_reg    <= DATA;
                     tick_cnt_reg <= '0;
                     bit_cnt_reg  <= '0;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  tick_cnt_reg <= tick_cnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt_reg == TICK_LAST) begin
                  shift_reg[bit_cnt_reg] <= rx_s_reg;
                  tick_cnt_reg           <= '0;
                  if (bit_cnt_reg == BIT_LAST) begin
                     state_reg    <= STOP;
                     stop_cnt_reg <= '0;
                     err_acc_reg  <= 1'b0;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end else begin
                  tick_cnt_reg <= tick_cnt_reg + 1'b1;
               end
            end
            STOP: begin
               if (tick_cnt_reg == TICK_LAST) begin
                  if (!rx_s_reg) err_acc_reg <= 1'b1;
                  // finishing at mid stop bit leaves half a bit to catch the next start edge
                  if (stop_cnt_reg == STOP_LAST) begin
                     data_out  <= shift_reg;
                     rx_done   <= 1'b1;
                     frame_err <= err_acc_reg | ~rx_s_reg;
                     state_reg <= IDLE;
                  end else begin
                     stop_cnt_reg <= stop_cnt_reg + 1'b1;
                     tick_cnt_reg <= '0;
                  end
               end else begin
                  tick_cnt_reg <= tick_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized bench for uart_receiver in two configurations
// (8/2/16 and 7/1/8), checked against a frame-level timing and content model.
module tb_uart_receiver;

   localparam int DW0 = 8, SB0 = 2, OS0 = 16;
   localparam int DW1 = 7, SB1 = 1, OS1 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst0_n, rst1_n, din0, din1;
   logic [DW0-1:0] dout0;
   logic [DW1-1:0] dout1;
   logic           done0, done1, ferr0, ferr1, busy0, busy1;

   uart_receiver #(.DATA_WIDTH_NUMBER(DW0), .STOP_BITS_NUMBER(SB0), .OVERSAMPLE(OS0)) dut0 (
      .rx_clk(clk), .rst_n(rst0_n), .rx_din(din0),
      .data_out(dout0), .rx_done(done0), .frame_err(ferr0), .busy(busy0));

   uart_receiver #(.DATA_WIDTH_NUMBER(DW1), .STOP_BITS_NUMBER(SB1), .OVERSAMPLE(OS1)) dut1 (
      .rx_clk(clk), .rst_n(rst1_n), .rx_din(din1),
      .data_out(dout1), .rx_done(done1), .frame_err(ferr1), .busy(busy1));

   typedef struct {
      int dut;
      int cyc;
      int data;
      int err;
      int bsy;
   } ev_t;

   ev_t got_q[$];
   ev_t exp_q[$];

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   rise0 = -1, fall0 = -1;
   logic busy0_d = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Completion monitor and busy-edge tracker, sampled on the falling edge
   always @(negedge clk) begin
      if (done0 === 1'b1) got_q.push_back('{0, cyc, int'(dout0), int'(ferr0), int'(busy0)});
      if (done1 === 1'b1) got_q.push_back('{1, cyc, int'(dout1), int'(ferr1), int'(busy1)});
      busy0_d <= busy0;
      if (busy0 === 1'b1 && busy0_d === 1'b0) rise0 <= cyc;
      if (busy0 === 1'b0 && busy0_d === 1'b1) fall0 <= cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int os_of(input int d); return d ? OS1 : OS0; endfunction
   function automatic int dw_of(input int d); return d ? DW1 : DW0; endfunction
   function automatic int sb_of(input int d); return d ? SB1 : SB0; endfunction

   // Hold the line of DUT d at level v for n bit-clock cycles (called on a falling edge)
   task automatic drive(input int d, input bit v, input int n);
      if (d == 0) din0 = v; else din1 = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_rst(input int d, input bit v);
      if (d == 0) rst0_n = v; else rst1_n = v;
   endtask

   // Sends one frame; stop bit s is driven low when stop_mask[s] is set.
   // The start edge is seen by the receiver three cycles after it is driven.
   task automatic send_frame(input int d, input logic [31:0] word, input logic [31:0] stop_mask);
      int os, dw, sb, e, err;
      os  = os_of(d);
      dw  = dw_of(d);
      sb  = sb_of(d);
      e   = cyc + 3;
      err = 0;
      drive(d, 1'b0, os);
      for (int i = 0; i < dw; i++) drive(d, word[i], os);
      for (int s = 0; s < sb; s++) begin
         if (stop_mask[s]) err = 1;
         drive(d, !stop_mask[s], os);
      end
      exp_q.push_back('{d, e + os / 2 + os * (dw + sb), int'(word) & ((1 << dw) - 1), err, 1});
   endtask

   task automatic check_events(input string tag);
      ev_t g, x;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         x = exp_q.pop_front();
         chk({tag, "_dut"}, g.dut, x.dut);
         chk({tag, "_cycle"}, g.cyc, x.cyc);
         chk({tag, "_data"}, g.data, x.data);
         chk({tag, "_ferr"}, g.err, x.err);
         chk({tag, "_busy"}, g.bsy, x.bsy);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Aborts a frame with a reset during data bit 3, then checks the receiver is clean
   task automatic reset_mid(input int d, input logic [31:0] word, input string tag);
      int os;
      os = os_of(d);
      drive(d, 1'b0, os);
      for (int i = 0; i < 3; i++) drive(d, word[i], os);
      drive(d, word[3], os / 2);
      set_rst(d, 1'b0);
      drive(d, 1'b1, 3);
      set_rst(d, 1'b1);
      drive(d, 1'b1, 2 * os);
      check_events({tag, "_abort"});
      if (d == 0) begin
         chk({tag, "_dout"}, 32'(dout0), 0);
         chk({tag, "_busy"}, 32'(busy0), 0);
      end else begin
         chk({tag, "_dout"}, 32'(dout1), 0);
         chk({tag, "_busy"}, 32'(busy1), 0);
      end
   endtask

   initial begin
      int e;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      din0   = 1'b1;
      din1   = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         din0 = i[0];
         din1 = ~i[0];
         @(negedge clk);
      end
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      din0   = 1'b1;
      din1   = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_dout0", 32'(dout0), 0);
      chk("rst_done0", 32'(done0), 0);
      chk("rst_ferr0", 32'(ferr0), 0);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_dout1", 32'(dout1), 0);
      chk("rst_busy1", 32'(busy1), 0);
      check_events("rst");

      // Nominal frame
      e = cyc + 3;
      send_frame(0, 32'hA5, 0);
      drive(0, 1'b1, OS0);
      chk("a5_busy_rise", rise0, e + 1);
      chk("a5_busy_fall", fall0, e + 169);
      check_events("a5");

      // Short low pulse is rejected at the start-bit midpoint
      e = cyc + 3;
      drive(0, 1'b0, 5);
      drive(0, 1'b1, 3 * OS0);
      chk("glitch_busy_rise", rise0, e + 1);
      chk("glitch_busy_fall", fall0, e + 9);
      chk("glitch_dout", 32'(dout0), 32'hA5);
      check_events("glitch");

      // Second stop bit low, then a break that must not retrigger
      send_frame(0, 32'h3C, 32'b10);
      drive(0, 1'b0, 3 * OS0);
      chk("break_busy", 32'(busy0), 0);
      check_events("ferr");
      chk("ferr_dout", 32'(dout0), 32'h3C);
      chk("ferr_flag", 32'(ferr0), 1);
      drive(0, 1'b1, OS0);
      send_frame(0, 32'h6E, 0);
      drive(0, 1'b1, OS0);
      check_events("after_break");
      chk("after_break_flag", 32'(ferr0), 0);

      // Back-to-back frames with no idle gap
      send_frame(0, 32'h00, 0);
      send_frame(0, 32'hFF, 0);
      send_frame(0, 32'h81, 0);
      drive(0, 1'b1, OS0);
      check_events("b2b");

      // Reset mid-frame, both configurations
      reset_mid(0, 32'h55, "rst_mid0");
      send_frame(0, 32'h12, 0);
      drive(0, 1'b1, OS0);
      check_events("post_rst0");
      reset_mid(1, 32'h2B, "rst_mid1");
      send_frame(1, 32'h5A, 0);
      drive(1, 1'b1, OS1);
      check_events("small_5a");

      // Randomized frames with occasional stop-bit errors and short idle gaps
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 20; n++) begin
            logic [31:0] w, m;
            w = $urandom;
            m = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, (1 << sb_of(d)) - 1)) : 32'd0;
            send_frame(d, w, m);
            drive(d, 1'b1, $urandom_range(1, os_of(d)));
         end
         drive(d, 1'b1, os_of(d));
         check_events(d ? "rand1" : "rand0");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
